// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side byte packer: FSM encoding and the
// width of byte-count fields.
package fifo_rd_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    // Width needed to hold a byte count in the range 0..pack inclusive.
    function automatic int cnt_w(input int pack);
        return $clog2(pack + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_packer_byte_accum.sv
// Byte accumulator: writes one byte per cycle at a given index, clear has priority.
// acc_nxt_o shows the contents including this cycle's write (zero latency view).
module byte_accum
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         we_i,
    input  logic                         clr_i,
    input  logic [cnt_w(PACK)-1:0]       idx_i,
    input  logic [DATA_WIDTH-1:0]        din_i,
    output logic [DATA_WIDTH*PACK-1:0]   acc_nxt_o
);

    localparam int CW = cnt_w(PACK);

    logic [DATA_WIDTH*PACK-1:0] acc_q;

    always_comb begin
        acc_nxt_o = acc_q;
        if (we_i) begin
            for (int i = 0; i < PACK; i++) begin
                if (idx_i == CW'(i)) begin
                    acc_nxt_o[i*DATA_WIDTH +: DATA_WIDTH] = din_i;
                end
            end
        end
    end

    // Clearing to zero after each word is what zero-fills the unused upper bytes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_nxt_o;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs FIFO read bytes into PACK-byte words; word registered the cycle the last byte lands.
// word held stable while word_ready is low; no FIFO reads issued outside FILL.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                        clk_rd,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        flush,
    input  logic                        empty,
    input  logic [DATA_WIDTH-1:0]       fifo_dout,
    output logic                        en_rd,
    output logic [DATA_WIDTH*PACK-1:0]  word,
    output logic [cnt_w(PACK)-1:0]      word_bytes,
    output logic                        word_valid,
    input  logic                        word_ready
);

    localparam int CW = cnt_w(PACK);
    localparam int WW = DATA_WIDTH * PACK;

    state_e         state_q, state_d;
    logic [CW-1:0]  acc_cnt_q, acc_cnt_d;
    logic           inflight_q;
    logic [WW-1:0]  word_q, word_d;
    logic [CW-1:0]  word_bytes_q, word_bytes_d;
    logic           word_valid_q, word_valid_d;
    logic           acc_clr;
    logic           load;
    logic [WW-1:0]  acc_view;
    logic [CW:0]    pending;

    // Bytes already held plus the one arriving this cycle from the FIFO.
    assign pending = {1'b0, acc_cnt_q} + {{CW{1'b0}}, inflight_q};
    assign en_rd   = en && !empty && (state_q == ST_FILL) && (pending < (CW+1)'(PACK));

    byte_accum #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK)
    ) u_accum (
        .clk_i      (clk_rd),
        .rst_ni     (rst),
        .we_i       (inflight_q),
        .clr_i      (acc_clr),
        .idx_i      (acc_cnt_q),
        .din_i      (fifo_dout),
        .acc_nxt_o  (acc_view)
    );

    always_comb begin
        state_d      = state_q;
        acc_cnt_d    = acc_cnt_q + CW'(inflight_q);
        word_d       = word_q;
        word_bytes_d = word_bytes_q;
        word_valid_d = word_valid_q;
        acc_clr      = 1'b0;
        load         = 1'b0;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_FILL;
            ST_FILL: begin
                if (acc_cnt_d == CW'(PACK)) begin
                    load = 1'b1;
                end else if (flush && (pending != '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: if (!inflight_q) load = 1'b1;
            ST_EMIT: begin
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = en ? ST_FILL : ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        // The final byte is merged straight into the word, so no cycle is lost to it.
        if (load) begin
            state_d      = ST_EMIT;
            word_d       = acc_view;
            word_bytes_d = acc_cnt_d;
            word_valid_d = 1'b1;
            acc_clr      = 1'b1;
            acc_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_rd or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            acc_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            word_q       <= '0;
            word_bytes_q <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_cnt_q    <= acc_cnt_d;
            inflight_q   <= en_rd;
            word_q       <= word_d;
            word_bytes_q <= word_bytes_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word       = word_q;
    assign word_bytes = word_bytes_q;
    assign word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (PACK=4) with a FIFO model and a word scoreboard.
module tb_fifo_rd_packer;

    typedef struct {
        logic [31:0] w;
        logic [2:0]  b;
    } exp_t;

    logic        clk_rd = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic        empty;
    logic [7:0]  fifo_dout = 8'h00;
    logic        en_rd;
    logic [31:0] word;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ready = 1'b0;

    logic [7:0]  fq[$];
    logic        empty_fifo = 1'b1;
    exp_t        exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt = 0, cur_run = 0, max_run = 0, wv_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_word = '0;
    logic [2:0]  prev_bytes = '0;

    assign empty = empty_fifo;

    always #5 clk_rd = ~clk_rd;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk_rd     (clk_rd),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .empty      (empty),
        .fifo_dout  (fifo_dout),
        .en_rd      (en_rd),
        .word       (word),
        .word_bytes (word_bytes),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // FIFO model: Dout valid the cycle after the read strobe.
    always @(posedge clk_rd) begin
        if (en_rd && fq.size() > 0) fifo_dout <= fq.pop_front();
        #1 empty_fifo = (fq.size() == 0);
    end

    // Monitor: scoreboard pop on handshake, hold stability, read/valid statistics.
    always @(negedge clk_rd) begin
        if (!rst) begin
            prev_hold = 1'b0;
        end else begin
            chk("rd_on_empty", {63'd0, en_rd & empty}, 64'd0);
            if (prev_hold) begin
                chk("hold_word", word, prev_word);
                chk("hold_bytes", word_bytes, prev_bytes);
                chk("hold_valid", word_valid, 1);
            end
            if (en_rd) begin
                rd_cnt++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
            end else begin
                cur_run = 0;
            end
            if (word_valid) wv_cnt++;
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", word, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word", word, e.w);
                    chk("word_bytes", word_bytes, e.b);
                end
            end
            prev_hold  = word_valid && !word_ready;
            prev_word  = word;
            prev_bytes = word_bytes;
        end
    end

    task automatic drive_step();
        @(posedge clk_rd);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) drive_step();
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        empty_fifo = 1'b0;
    endtask

    task automatic expect_word(input logic [31:0] w, input logic [2:0] b);
        exp_t e;
        e.w = w;
        e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic clr_stats();
        rd_cnt = 0; cur_run = 0; max_run = 0; wv_cnt = 0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk_rd);
        chk({"drain_", tag}, exp_q.size(), 0);
        cycles(3);
    endtask

    initial begin
        // Reset state
        cycles(2);
        @(negedge clk_rd);
        chk("rst_en_rd", en_rd, 0);
        chk("rst_word", word, 0);
        chk("rst_word_bytes", word_bytes, 0);
        chk("rst_word_valid", word_valid, 0);
        drive_step();
        rst = 1'b1;
        cycles(2);

        // Four bytes straight through
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        expect_word(32'h44332211, 3'd4);
        clr_stats();
        en = 1'b1;
        word_ready = 1'b1;
        wait_drain("basic");
        chk("basic_rd_cnt", rd_cnt, 4);
        chk("basic_rd_run", max_run, 4);
        chk("basic_wv_cycles", wv_cnt, 1);

        // Partial word emitted by flush
        push(8'hA1); push(8'hA2);
        cycles(6);
        expect_word(32'h0000A2A1, 3'd2);
        flush = 1'b1;
        drive_step();
        flush = 1'b0;
        wait_drain("flush");

        // Flush with nothing accumulated produces nothing
        clr_stats();
        flush = 1'b1;
        drive_step();
        flush = 1'b0;
        cycles(6);
        chk("empty_flush_wv", wv_cnt, 0);

        // Backpressure: first word held for 5 cycles
        word_ready = 1'b0;
        clr_stats();
        for (int i = 1; i <= 8; i++) push(8'(i));
        expect_word(32'h04030201, 3'd4);
        expect_word(32'h08070605, 3'd4);
        for (int i = 0; i < 30 && !word_valid; i++) @(negedge clk_rd);
        chk("bp_first_valid", word_valid, 1);
        cycles(5);
        @(negedge clk_rd);
        chk("bp_still_valid", word_valid, 1);
        chk("bp_held_word", word, 32'h04030201);
        drive_step();
        word_ready = 1'b1;
        wait_drain("backpressure");
        chk("bp_rd_cnt", rd_cnt, 8);

        // Empty rises right after the read of the last byte
        clr_stats();
        push(8'h7E);
        cycles(5);
        chk("empty_rd_cnt", rd_cnt, 1);
        chk("empty_no_word", wv_cnt, 0);
        push(8'h7F); push(8'h80); push(8'h81);
        expect_word(32'h81807F7E, 3'd4);
        wait_drain("empty_inflight");

        // Enable dropped mid-word retains partial bytes
        push(8'h91); push(8'h92);
        cycles(6);
        en = 1'b0;
        clr_stats();
        push(8'h93); push(8'h94);
        cycles(5);
        chk("en_low_rd_cnt", rd_cnt, 0);
        chk("en_low_wv", wv_cnt, 0);
        expect_word(32'h94939291, 3'd4);
        en = 1'b1;
        wait_drain("en_resume");

        // Reset mid-word discards partial and in-flight bytes
        clr_stats();
        push(8'hC1); push(8'hC2); push(8'hC3);
        for (int i = 0; i < 30 && rd_cnt < 3; i++) @(negedge clk_rd);
        chk("rst_mid_reads", rd_cnt, 3);
        drive_step();
        rst = 1'b0;
        @(negedge clk_rd);
        chk("rst_mid_en_rd", en_rd, 0);
        chk("rst_mid_word", word, 0);
        chk("rst_mid_bytes", word_bytes, 0);
        chk("rst_mid_valid", word_valid, 0);
        drive_step();
        rst = 1'b1;
        push(8'h55); push(8'h56); push(8'h57); push(8'h58);
        expect_word(32'h58575655, 3'd4);
        wait_drain("after_reset");

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
